seg_display_scanner: RTL
========================

# seg_display_scanner

Output stage of the CPU's debug display path: consumes the 32-bit register-file display word and drives the 4-digit multiplexed 7-segment display. It captures the word on a strobe, selects a halfword page, optionally converts it to decimal with a sequential double-dabble engine, and commits the result atomically to a digit buffer. A free-running refresh scanner then drives the active-low anodes and segments. The whole block is registered.

## Interface
- REFRESH_DIV, 50000: clk cycles each digit stays lit; legal range ≥1.

- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low; clears all state immediately.
- data_in  in  32  display word from the register file.
- load  in  1  capture strobe; data_in is sampled on every cycle load=1.
- page  in  1  0: display data[15:0]; 1: display data[31:16].
- dec_mode  in  1  0: hex; 1: unsigned decimal.
- blank_lz  in  1  1: blank leading zero digits.
- seg  out  7  segments, active-low, {g,f,e,d,c,b,a}.
- an  out  4  digit anodes, active-low; an[0] is the rightmost, least-significant digit.
- busy  out  1  a conversion or commit is in progress.

## Operation
- Capture register cap. Trigger condition: load=1, or page or dec_mode differs from its value in the previous cycle, detected by registered copies. On a trigger, cap is updated to data_in only if load=1. The selected halfword h = page ? cap[31:16] : cap[15:0], evaluated from the post-trigger cap.
- FSM states:
  - IDLE: trigger → CONV if dec_mode, else COMMIT.
  - CONV: 16 double-dabble steps on h. Add 3 to each BCD nibble ≥5, then shift left one bit. 20-bit BCD result. After step 16 → COMMIT.
  - COMMIT: writes the digit buffer in one edge → IDLE.
- A trigger in CONV or COMMIT restarts: the FSM re-enters CONV or COMMIT per the new dec_mode, the step count is reset, and the in-flight result is discarded. The buffer is not written by the aborted run.
- Commit content:
  - Hex: the four nibbles of h.
  - Decimal with h ≤ 9999: the four low BCD digits.
  - Decimal with h > 9999: overflow, all four digits show a dash.
- Blanking: when blank_lz=1, digits above the most-significant nonzero digit are blanked. Digit 0 is never blanked. The overflow pattern is never blanked. blank_lz is applied at scan time, not at commit.
- Scanner:
  - Prescaler counts 0..REFRESH_DIV-1. At terminal count it wraps to 0 and digit index idx increments mod 4 (3→0).
  - an = ~(4'b0001 << idx); exactly one anode is low at all times.
- Segment codes, active-low gfedcba: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110, dash=0111111, blank=1111111.

## Timing
- Reset values: cap=0, buffer=all-zero digits, FSM=IDLE, idx=0, prescaler=0, busy=0, an=4'b1110, seg=1000000. Previous-page and previous-mode copies are reset to 0.
- seg and an are registered. Both update on the same edge, one cycle after idx or the buffer changes, so there is no ghosting between digits.
- Hex trigger at edge N: busy=1 after N, buffer written at N+1, busy=0 after N+1.
- Decimal trigger at edge N: CONV steps at edges N+1..N+16, COMMIT write at N+17. busy is high for 17 cycles.
- The digit buffer holds its old value throughout a conversion; the display never tears.
- With REFRESH_DIV=1, idx advances every cycle.
- An rst assertion mid-conversion aborts the conversion and restores the reset values asynchronously. The first trigger is accepted at the first edge after deassertion.

## Test plan
- Reset with REFRESH_DIV=4 → an=1110, seg=1000000, busy=0; an then cycles 1110→1101→1011→0111→1110 every 4 clocks.
- Hex: load 0x0000BEEF with page=0 → busy high exactly 1 cycle; digits 3..0 show B,E,E,F (0000011,0000110,0000110,0001110). Set page=1 without load → display 0000.
- Decimal: load 0x00000F3C (3900) with dec_mode=1 → busy high 17 cycles; digits show 3,9,0,0. Load 0x0000270F (9999) → 9999. Load 0x00002710 (10000) → four dashes.
- Leading zeros: blank_lz=1, decimal 0x00000007 → digits 3..1 show 1111111 and digit 0 shows 7. Value 0 → digit 0 shows 0.
- Restart: decimal load of 1234, then load of 42 at step 8 → buffer never shows 1234; shows 0042 exactly 17 cycles after the second load.
- Pull rst low at step 10 of a conversion → outputs return to reset values immediately. After release, the buffer remains all-zero until a new load.

Source files
------------

// File: rtl/seg_display_scanner.sv
// 4-digit multiplexed 7-segment driver: captures a display word, optionally converts
// the selected halfword to BCD with a serial double-dabble engine, then scans the digits.
module seg_display_scanner #(
   parameter int REFRESH_DIV = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] data_in,
   input  logic        load,
   input  logic        page,
   input  logic        dec_mode,
   input  logic        blank_lz,
   output logic [6:0]  seg,
   output logic [3:0]  an,
   output logic        busy
);

   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

   state_t              state, state_nxt;
   logic [31:0]         cap, cap_nxt;
   logic                prev_page, prev_mode, mode_r;
   logic                trig, commit_we;
   logic [15:0]         h_nxt, work;
   logic [19:0]         bcd, bcd_adj;
   logic [3:0]          step;
   logic [3:0][3:0]     dig_buf;
   logic                ovf_buf;
   logic [PW-1:0]       presc;
   logic [1:0]          idx;
   logic [3:0]          zero_above;
   logic [6:0]          seg_nxt;

   function automatic logic [6:0] seg_code(input logic [3:0] d);
      case (d)
         4'h0: seg_code = 7'b1000000;
         4'h1: seg_code = 7'b1111001;
         4'h2: seg_code = 7'b0100100;
         4'h3: seg_code = 7'b0110000;
         4'h4: seg_code = 7'b0011001;
         4'h5: seg_code = 7'b0010010;
         4'h6: seg_code = 7'b0000010;
         4'h7: seg_code = 7'b1111000;
         4'h8: seg_code = 7'b0000000;
         4'h9: seg_code = 7'b0010000;
         4'hA: seg_code = 7'b0001000;
         4'hB: seg_code = 7'b0000011;
         4'hC: seg_code = 7'b1000110;
         4'hD: seg_code = 7'b0100001;
         4'hE: seg_code = 7'b0000110;
         default: seg_code = 7'b0001110;
      endcase
   endfunction

   // A mode or page change re-renders the display even without a new capture.
   assign trig  = load | (page != prev_page) | (dec_mode != prev_mode);
   assign cap_nxt = load ? data_in : cap;
   assign h_nxt = page ? cap_nxt[31:16] : cap_nxt[15:0];
   assign busy  = (state != IDLE);

   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < 5; i++)
         if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
   end

   always_comb begin
      state_nxt = state;
      commit_we = 1'b0;
      if (trig) begin
         state_nxt = dec_mode ? CONV : COMMIT;
      end else begin
         case (state)
            CONV:    if (step == 4'd15) state_nxt = COMMIT;
            COMMIT: begin
               commit_we = 1'b1;
               state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cap       <= '0;
         prev_page <= 1'b0;
         prev_mode <= 1'b0;
         mode_r    <= 1'b0;
         work      <= '0;
         bcd       <= '0;
         step      <= '0;
         dig_buf   <= '0;
         ovf_buf   <= 1'b0;
      end else begin
         prev_page <= page;
         prev_mode <= dec_mode;
         if (trig) begin
            cap    <= cap_nxt;
            work   <= h_nxt;
            bcd    <= '0;
            step   <= '0;
            mode_r <= dec_mode;
         end else if (state == CONV) begin
            {bcd, work} <= {bcd_adj[18:0], work, 1'b0};
            step        <= step + 4'd1;
         end
         // The buffer only changes here, so a running conversion never tears the display.
         if (commit_we) begin
            if (mode_r) begin
               dig_buf <= bcd[15:0];
               ovf_buf <= |bcd[19:16];
            end else begin
               dig_buf <= work;
               ovf_buf <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      zero_above[3] = (dig_buf[3] == 4'd0);
      for (int i = 2; i >= 0; i--)
         zero_above[i] = zero_above[i+1] && (dig_buf[i] == 4'd0);
   end

   always_comb begin
      seg_nxt = seg_code(dig_buf[idx]);
      if (ovf_buf)
         seg_nxt = 7'b0111111;
      else if (blank_lz && idx != 2'd0 && zero_above[idx])
         seg_nxt = 7'b1111111;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc <= '0;
         idx   <= '0;
         seg   <= 7'b1000000;
         an    <= 4'b1110;
      end else begin
         if (presc == PW'(REFRESH_DIV - 1)) begin
            presc <= '0;
            idx   <= idx + 2'd1;
         end else begin
            presc <= presc + 1'b1;
         end
         seg <= seg_nxt;
         an  <= ~(4'b0001 << idx);
      end
   end

endmodule
